sd_pic_loader: RTL and testbench

//   Converts the raw SD-card byte stream of one picture file into SDRAM pixel writes for a selectable frame slot.

---
 rtl/sd_pic_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_sd_pic_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_pic_loader.sv
// Turns the byte stream of one picture file into RGB565 pixel writes with linear SDRAM word addresses.
// Drops a fixed-size header, packs RGB565/BGR888 input, and optionally writes rows bottom-up.
module sd_pic_loader #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int HDR_BYTES   = 54,
    parameter int NUM_SLOTS   = 4,
    parameter int SLOT_W      = 2,
    parameter int ADDR_W      = 21,
    parameter int SLOT_STRIDE = 524288,
    parameter int FLIP_V      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SLOT_W-1:0] slot_sel,
    input  logic              fmt,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              pix_valid,
    output logic [15:0]       pix_data,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic              pix_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int HDR_W = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(V_RES - 1);
    localparam logic [HDR_W-1:0]  HDR_LAST = HDR_W'(HDR_BYTES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] FLIP_OFS = (FLIP_V != 0) ? ADDR_W'((V_RES - 1) * H_RES) : {ADDR_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              fmt_q, fmt_d;
    logic [HDR_W-1:0]  hdr_cnt_q, hdr_cnt_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic              last_q, last_d;
    logic              pix_valid_q, pix_valid_d;
    logic [15:0]       pix_data_q, pix_data_d;
    logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic              byte_ready_s;
    logic              byte_fire_s;
    logic              pix_fire_s;
    logic [1:0]        last_idx_s;

    // Slot base via a constant lookup so no multiplier is built for slot_sel.
    function automatic logic [ADDR_W-1:0] slot_base(input logic [SLOT_W-1:0] s);
        logic [ADDR_W-1:0] b;
        b = {ADDR_W{1'b0}};
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (s == SLOT_W'(i)) begin
                b = ADDR_W'(i * SLOT_STRIDE);
            end
        end
        return b;
    endfunction

    // Once the final pixel is loaded no further bytes are taken, so trailing bytes stay upstream.
    assign byte_ready_s = (state_q == ST_HDR) |
                          ((state_q == ST_PIX) & ~last_q & (~pix_valid_q | pix_ready));
    assign byte_fire_s  = byte_valid & byte_ready_s;
    assign pix_fire_s   = pix_valid_q & pix_ready;
    assign last_idx_s   = fmt_q ? 2'd2 : 2'd1;

    // Next-state and datapath computation for the loader.
    always_comb begin
        state_d      = state_q;
        fmt_d        = fmt_q;
        hdr_cnt_d    = hdr_cnt_q;
        byte_idx_d   = byte_idx_q;
        b0_d         = b0_q;
        b1_d         = b1_q;
        col_d        = col_q;
        row_d        = row_q;
        line_base_d  = line_base_q;
        last_d       = last_q;
        pix_valid_d  = pix_valid_q;
        pix_data_d   = pix_data_q;
        pix_addr_d   = pix_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    fmt_d       = fmt;
                    hdr_cnt_d   = {HDR_W{1'b0}};
                    byte_idx_d  = 2'd0;
                    col_d       = {COL_W{1'b0}};
                    row_d       = {ROW_W{1'b0}};
                    last_d      = 1'b0;
                    line_base_d = slot_base(slot_sel) + FLIP_OFS;
                    state_d     = (HDR_BYTES == 0) ? ST_PIX : ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (byte_fire_s) begin
                    if (hdr_cnt_q == HDR_LAST) begin
                        state_d = ST_PIX;
                    end else begin
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PIX: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    pix_valid_d = 1'b0;
                end else begin
                    if (pix_fire_s) begin
                        pix_valid_d = 1'b0;
                        state_d     = last_q ? ST_DONE : ST_PIX;
                    end else begin
                        pix_valid_d = pix_valid_q;
                    end
                    if (byte_fire_s) begin
                        if (byte_idx_q == last_idx_s) begin
                            byte_idx_d  = 2'd0;
                            pix_valid_d = 1'b1;
                            pix_data_d  = fmt_q ? {byte_data[7:3], b1_q[7:2], b0_q[7:3]}
                                                : {byte_data, b0_q};
                            pix_addr_d  = line_base_q + ADDR_W'(col_q);
                            if (col_q == COL_LAST) begin
                                col_d       = {COL_W{1'b0}};
                                row_d       = row_q + 1'b1;
                                line_base_d = (FLIP_V != 0) ? (line_base_q - ROW_STEP)
                                                            : (line_base_q + ROW_STEP);
                                last_d      = (row_q == ROW_LAST);
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd0) begin
                                b0_d = byte_data;
                            end else begin
                                b1_d = byte_data;
                            end
                        end
                    end else begin
                        byte_idx_d = byte_idx_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d       = (state_d == ST_HDR) || (state_d == ST_PIX);
        frame_done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            fmt_q        <= 1'b0;
            hdr_cnt_q    <= {HDR_W{1'b0}};
            byte_idx_q   <= 2'd0;
            b0_q         <= 8'd0;
            b1_q         <= 8'd0;
            col_q        <= {COL_W{1'b0}};
            row_q        <= {ROW_W{1'b0}};
            line_base_q  <= {ADDR_W{1'b0}};
            last_q       <= 1'b0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= 16'd0;
            pix_addr_q   <= {ADDR_W{1'b0}};
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fmt_q        <= fmt_d;
            hdr_cnt_q    <= hdr_cnt_d;
            byte_idx_q   <= byte_idx_d;
            b0_q         <= b0_d;
            b1_q         <= b1_d;
            col_q        <= col_d;
            row_q        <= row_d;
            line_base_q  <= line_base_d;
            last_q       <= last_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign byte_ready = byte_ready_s;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_addr   = pix_addr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sd_pic_loader.sv
// Scoreboard bench for sd_pic_loader: one top-down and one bottom-up instance share the same stimulus.
module tb_sd_pic_loader;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int HB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  slot_sel = 2'd0;
    logic        fmt = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        pix_ready = 1'b0;
    logic [1:0]  br, pv, busy_o, fd;
    logic [15:0] pd [2];
    logic [7:0]  pa [2];

    always #5 clk = ~clk;

    sd_pic_loader #(.H_RES(H), .V_RES(V), .HDR_BYTES(HB), .NUM_SLOTS(4), .SLOT_W(2),
                    .ADDR_W(8), .SLOT_STRIDE(16), .FLIP_V(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .slot_sel(slot_sel), .fmt(fmt),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br[0]),
        .pix_valid(pv[0]), .pix_data(pd[0]), .pix_addr(pa[0]), .pix_ready(pix_ready),
        .busy(busy_o[0]), .frame_done(fd[0]));

    sd_pic_loader #(.H_RES(H), .V_RES(V), .HDR_BYTES(HB), .NUM_SLOTS(4), .SLOT_W(2),
                    .ADDR_W(8), .SLOT_STRIDE(16), .FLIP_V(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .slot_sel(slot_sel), .fmt(fmt),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(br[1]),
        .pix_valid(pv[1]), .pix_data(pd[1]), .pix_addr(pa[1]), .pix_ready(pix_ready),
        .busy(busy_o[1]), .frame_done(fd[1]));

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  a;
        logic        last;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   stall_until = 0;
    int   exp_frames = 0;
    int   timeouts = 0;
    int   done_cnt [2];
    int   done_due [2];
    bit   expect_rst = 1'b0;
    bit   expect_idle = 1'b0;
    bit   expect_no_br = 1'b0;
    bit   final_chk = 1'b0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0h required=%0h", nm, i, act, req);
        end
    endtask

    // Reference pixel: colour packing and the address of pixel k counted in file order.
    function automatic exp_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                                input int f, input int k, input int slot, input int flip, input bit last);
        exp_t e;
        int   row;
        row    = k / H;
        if (flip != 0) row = V - 1 - row;
        e.d    = (f != 0) ? {b2[7:3], b1[7:2], b0[7:3]} : {b1, b0};
        e.a    = 8'(slot * 16 + row * H + k % H);
        e.last = last;
        return e;
    endfunction

    // Monitor: all comparisons happen here, on the falling edge.
    initial begin
        exp_t        e;
        bit          got;
        logic [1:0]  prev_stall;
        logic [15:0] prev_pd [2];
        logic [7:0]  prev_pa [2];
        prev_stall = 2'b00;
        for (int i = 0; i < 2; i++) begin
            done_cnt[i] = 0;
            done_due[i] = -1;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (expect_rst) begin
                    chk("rst_pix_valid", i, 32'(pv[i]), 32'd0);
                    chk("rst_pix_data", i, 32'(pd[i]), 32'd0);
                    chk("rst_pix_addr", i, 32'(pa[i]), 32'd0);
                    chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
                    chk("rst_frame_done", i, 32'(fd[i]), 32'd0);
                    chk("rst_byte_ready", i, 32'(br[i]), 32'd0);
                end
                if (expect_idle) begin
                    chk("abort_pix_valid", i, 32'(pv[i]), 32'd0);
                    chk("abort_busy", i, 32'(busy_o[i]), 32'd0);
                end
                if (expect_no_br) chk("spare_byte_ready", i, 32'(br[i]), 32'd0);
                if (pv[i] === 1'b1 && pix_ready === 1'b0) begin
                    chk("stall_byte_ready", i, 32'(br[i]), 32'd0);
                    if (prev_stall[i]) begin
                        chk("stall_data_stable", i, 32'(pd[i]), 32'(prev_pd[i]));
                        chk("stall_addr_stable", i, 32'(pa[i]), 32'(prev_pa[i]));
                    end
                    prev_stall[i] = 1'b1;
                    prev_pd[i]    = pd[i];
                    prev_pa[i]    = pa[i];
                end else begin
                    prev_stall[i] = 1'b0;
                end
                if (pv[i] === 1'b1 && pix_ready === 1'b1) begin
                    got = 1'b1;
                    if (i == 0 && qa.size() > 0) e = qa.pop_front();
                    else if (i == 1 && qb.size() > 0) e = qb.pop_front();
                    else got = 1'b0;
                    if (got) begin
                        chk("pix_data", i, 32'(pd[i]), 32'(e.d));
                        chk("pix_addr", i, 32'(pa[i]), 32'(e.a));
                        if (e.last) done_due[i] = cyc + 1;
                    end else begin
                        chk("unexpected_pixel", i, 32'd1, 32'd0);
                    end
                end
                if (fd[i] === 1'b1) begin
                    chk("frame_done_timing", i, 32'(cyc), 32'(done_due[i]));
                    done_cnt[i]++;
                end
                if (final_chk) chk("frame_count", i, 32'(done_cnt[i]), 32'(exp_frames));
            end
            if (final_chk) begin
                chk("leftover_expected", 0, 32'(qa.size() + qb.size()), 32'd0);
                chk("timeouts", 0, 32'(timeouts), 32'd0);
            end
        end
    end

    // Downstream ready: random backpressure, forced low during requested stall windows.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_ready = (cyc < stall_until) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (br[0] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeouts++;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_abort(input bit use_rst);
        stall_until = cyc + 3;
        @(posedge clk);
        #1;
        if (use_rst) rst_n = 1'b0;
        else abort = 1'b1;
        @(posedge clk);
        #1;
        abort       = 1'b0;
        rst_n       = 1'b1;
        expect_idle = 1'b1;
        expect_rst  = use_rst;
        @(posedge clk);
        #1;
        expect_idle = 1'b0;
        expect_rst  = 1'b0;
        qa.delete();
        qb.delete();
    endtask

    task automatic wait_done();
        int t;
        for (t = 0; t < 300; t++) begin
            if (done_cnt[0] == exp_frames && done_cnt[1] == exp_frames &&
                qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (t == 300) timeouts++;
    endtask

    // mode 0: plain frame; 1: abort after 3 pixels; 2: reset after 3 pixels; 3: stall, stray starts, spare bytes.
    task automatic run_frame(input int slot, input int f, input int mode, input bit vec);
        logic [7:0] bytes[$];
        logic [7:0] b2v;
        int         bpp;
        int         k;
        int         p;
        bit         ok;
        bpp = (f != 0) ? 3 : 2;
        for (int n = 0; n < HB + 8 * bpp; n++) bytes.push_back(8'($urandom_range(0, 255)));
        if (vec && f == 0) begin
            bytes[0] = 8'hAA; bytes[1] = 8'hBB; bytes[2] = 8'hCC;
            bytes[3] = 8'h34; bytes[4] = 8'h12; bytes[5] = 8'h78; bytes[6] = 8'h56;
        end else if (vec) begin
            bytes[3] = 8'hFF; bytes[4] = 8'h00; bytes[5] = 8'hF8;
            bytes[6] = 8'h00; bytes[7] = 8'hFF; bytes[8] = 8'h00;
        end
        if (mode == 0 || mode == 3) exp_frames++;
        start    = 1'b1;
        slot_sel = 2'(slot);
        fmt      = f[0];
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 0; n < bytes.size(); n++) begin
            send_byte(bytes[n], ok);
            if (!ok) return;
            if (n >= HB && (n - HB) % bpp == bpp - 1) begin
                k   = (n - HB) / bpp;
                p   = n - bpp + 1;
                b2v = (bpp == 3) ? bytes[p + 2] : 8'h00;
                qa.push_back(mk(bytes[p], bytes[p + 1], b2v, f, k, slot, 0, k == 7));
                qb.push_back(mk(bytes[p], bytes[p + 1], b2v, f, k, slot, 1, k == 7));
                if ((mode == 1 || mode == 2) && k == 2) begin
                    do_abort(mode == 2);
                    return;
                end
                if (mode == 3 && k == 1) stall_until = cyc + 6;
                if (mode == 3 && k == 4) begin
                    start    = 1'b1;
                    slot_sel = 2'(slot + 1);
                    fmt      = ~f[0];
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        end
        if (mode == 3) begin
            byte_valid   = 1'b1;
            byte_data    = 8'h5A;
            start        = 1'b1;
            expect_no_br = 1'b1;
            @(posedge clk);
            #1;
            start     = 1'b0;
            byte_data = 8'hA5;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            byte_valid   = 1'b0;
            expect_no_br = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        @(posedge clk);
        #1;
        expect_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_rst = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1, 0, 0, 1'b1);
        run_frame(2, 1, 0, 1'b1);
        run_frame(0, 0, 1, 1'b0);
        run_frame(0, 1, 0, 1'b0);
        run_frame(3, 1, 2, 1'b0);
        run_frame(1, 0, 3, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), (r % 2 == 1) ? 3 : 0, 1'b0);
        end
        repeat (3) @(posedge clk);
        #1;
        final_chk = 1'b1;
        @(posedge clk);
        #1;
        final_chk = 1'b0;
        @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
